axi_dma_r: RTL and testbench

AXI4 read-burst master for the DMA engine; it is the read-side counterpart of the DMA write channel. It takes a single-request native databus command (addr, len), issues one INCR read burst to the MIG/DDR interconnect, and returns each beat to the databus as registered rdata qualified by a one-cycle ready pulse. At the end of each burst it checks the response and the burst length, and reports the outcome in an error flag.

---
 rtl/axi_dma_r_pkg.sv | 37 +++
 rtl/axi_dma_r.sv | 166 ++++++++++++++++
 tb/tb_axi_dma_r.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_r_pkg.sv
// Shared definitions for the DMA AXI4 read-burst master: bus widths,
// fixed AR-channel attribute values, FSM state encoding and response helper.
package axi_dma_r_pkg;

   localparam int MIG_BUS_W   = 64;
   localparam int DDR_ADDR_W  = 32;
   localparam int AXI_ID_W    = 4;
   localparam int AXI_LEN_W   = 8;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_LOCK_W  = 1;
   localparam int AXI_CACHE_W = 4;
   localparam int AXI_PROT_W  = 3;
   localparam int AXI_QOS_W   = 4;
   localparam int AXI_RESP_W  = 2;

   // Beat counter is one bit wider than arlen so a 256-beat burst never wraps.
   localparam int CNT_W = AXI_LEN_W + 1;

   localparam logic [AXI_BURST_W-1:0] BURST_INCR = 2'b01;
   localparam logic [AXI_CACHE_W-1:0] CACHE_MOD  = 4'h2;
   localparam logic [AXI_PROT_W-1:0]  PROT_DATA  = 3'b010;
   localparam logic [AXI_RESP_W-1:0]  RESP_OKAY  = 2'b00;
   localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE   = AXI_SIZE_W'($clog2(MIG_BUS_W / 8));

   typedef enum logic [1:0] {
      R_ADDR_HS = 2'd0,
      R_DATA    = 2'd1,
      R_DONE    = 2'd2
   } r_state_e;

   // Any response other than OKAY (SLVERR/DECERR/EXOKAY) marks the burst bad.
   function automatic logic resp_is_error(input logic [AXI_RESP_W-1:0] resp);
      return (resp != RESP_OKAY);
   endfunction

endpackage

// File: rtl/axi_dma_r.sv
// AXI4 read-burst master: one databus request -> one INCR read burst.
// Each accepted beat is returned as rdata with a one-cycle ready pulse;
// response and burst-length faults are collected and published on error
// in the idle cycle that follows the burst.
module axi_dma_r
   import axi_dma_r_pkg::*;
#(
   parameter int unsigned AXI_ID   = 0,
   parameter bit          DATA_REG = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid,
   input  logic [DDR_ADDR_W-1:0]  addr,
   input  logic [AXI_LEN_W-1:0]   len,
   output logic                   ready,
   output logic [MIG_BUS_W-1:0]   rdata,
   output logic                   last,
   output logic                   error,
   output logic [AXI_ID_W-1:0]    m_axi_arid,
   output logic [DDR_ADDR_W-1:0]  m_axi_araddr,
   output logic [AXI_LEN_W-1:0]   m_axi_arlen,
   output logic [AXI_SIZE_W-1:0]  m_axi_arsize,
   output logic [AXI_BURST_W-1:0] m_axi_arburst,
   output logic [AXI_LOCK_W-1:0]  m_axi_arlock,
   output logic [AXI_CACHE_W-1:0] m_axi_arcache,
   output logic [AXI_PROT_W-1:0]  m_axi_arprot,
   output logic [AXI_QOS_W-1:0]   m_axi_arqos,
   output logic                   m_axi_arvalid,
   input  logic                   m_axi_arready,
   input  logic [MIG_BUS_W-1:0]   m_axi_rdata,
   input  logic [AXI_RESP_W-1:0]  m_axi_rresp,
   input  logic                   m_axi_rlast,
   input  logic                   m_axi_rvalid,
   output logic                   m_axi_rready
);

   r_state_e             state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [AXI_LEN_W-1:0] len_q, len_d;
   logic                 berr_q, berr_d;
   logic                 error_q, error_d;

   logic                 arvalid_s;
   logic                 rready_s;
   logic                 beat_s;
   logic                 len_match_s;

   // Fixed AR attributes; address and length come straight from the request.
   assign m_axi_arid    = AXI_ID_W'(AXI_ID);
   assign m_axi_araddr  = addr;
   assign m_axi_arlen   = len;
   assign m_axi_arsize  = AXI_SIZE;
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arlock  = {AXI_LOCK_W{1'b0}};
   assign m_axi_arcache = CACHE_MOD;
   assign m_axi_arprot  = PROT_DATA;
   assign m_axi_arqos   = {AXI_QOS_W{1'b0}};

   // arvalid is forced low while reset is asserted, even if valid is still held.
   assign m_axi_arvalid = arvalid_s & rst;
   assign m_axi_rready  = rready_s;
   assign error         = error_q;

   // The current beat is the expected final one when the count reaches arlen.
   assign len_match_s = (cnt_q == {1'b0, len_q});

   // Next-state logic: address handshake, beat accounting, end-of-burst report.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      berr_d    = berr_q;
      error_d   = error_q;
      arvalid_s = 1'b0;
      rready_s  = 1'b0;
      beat_s    = 1'b0;
      case (state_q)
         R_ADDR_HS: begin
            cnt_d     = {CNT_W{1'b0}};
            arvalid_s = valid;
            if (valid && m_axi_arready) begin
               berr_d  = 1'b0;
               len_d   = len;
               state_d = R_DATA;
            end else begin
               state_d = R_ADDR_HS;
            end
         end
         R_DATA: begin
            rready_s = 1'b1;
            if (m_axi_rvalid) begin
               beat_s = 1'b1;
               cnt_d  = cnt_q + CNT_W'(1);
               // rlast early, or the expected final beat without rlast, is a length fault.
               berr_d = berr_q | resp_is_error(m_axi_rresp) | (m_axi_rlast != len_match_s);
               if (m_axi_rlast) begin
                  state_d = R_DONE;
               end else begin
                  state_d = R_DATA;
               end
            end else begin
               state_d = R_DATA;
            end
         end
         R_DONE: begin
            error_d = berr_q;
            state_d = R_ADDR_HS;
         end
         default: begin
            state_d = R_ADDR_HS;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= R_ADDR_HS;
         cnt_q   <= {CNT_W{1'b0}};
         len_q   <= {AXI_LEN_W{1'b0}};
         berr_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         berr_q  <= berr_d;
         error_q <= error_d;
      end
   end

   generate
      if (DATA_REG) begin : g_data_reg
         logic                 ready_q;
         logic                 last_q;
         logic [MIG_BUS_W-1:0] rdata_q;

         // Beat return stage: one cycle after the AXI handshake.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ready_q <= 1'b0;
               last_q  <= 1'b0;
               rdata_q <= {MIG_BUS_W{1'b0}};
            end else begin
               ready_q <= beat_s;
               last_q  <= beat_s & m_axi_rlast;
               if (beat_s) begin
                  rdata_q <= m_axi_rdata;
               end else begin
                  rdata_q <= rdata_q;
               end
            end
         end

         assign ready = ready_q;
         assign last  = last_q;
         assign rdata = rdata_q;
      end else begin : g_data_comb
         assign ready = beat_s;
         assign last  = beat_s & m_axi_rlast;
         assign rdata = beat_s ? m_axi_rdata : {MIG_BUS_W{1'b0}};
      end
   endgenerate

endmodule

// File: tb/tb_axi_dma_r.sv
// Bench for axi_dma_r (DATA_REG=1): directed table of bursts, hand-written
// reset/idle sequences, then randomized bursts. Expected beats, timing and
// error come from a simple burst-level model (beats driven vs. len+1, any
// non-OKAY response).
module tb_axi_dma_r;
   import axi_dma_r_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   valid = 1'b0;
   logic [DDR_ADDR_W-1:0]  addr = '0;
   logic [AXI_LEN_W-1:0]   len = '0;
   logic                   ready;
   logic [MIG_BUS_W-1:0]   rdata;
   logic                   last;
   logic                   error;
   logic [AXI_ID_W-1:0]    m_axi_arid;
   logic [DDR_ADDR_W-1:0]  m_axi_araddr;
   logic [AXI_LEN_W-1:0]   m_axi_arlen;
   logic [AXI_SIZE_W-1:0]  m_axi_arsize;
   logic [AXI_BURST_W-1:0] m_axi_arburst;
   logic [AXI_LOCK_W-1:0]  m_axi_arlock;
   logic [AXI_CACHE_W-1:0] m_axi_arcache;
   logic [AXI_PROT_W-1:0]  m_axi_arprot;
   logic [AXI_QOS_W-1:0]   m_axi_arqos;
   logic                   m_axi_arvalid;
   logic                   m_axi_arready = 1'b0;
   logic [MIG_BUS_W-1:0]   m_axi_rdata = '0;
   logic [AXI_RESP_W-1:0]  m_axi_rresp = '0;
   logic                   m_axi_rlast = 1'b0;
   logic                   m_axi_rvalid = 1'b0;
   logic                   m_axi_rready;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int prev_err = 0;

   logic [63:0] got_data[$];
   logic [63:0] exp_data[$];
   bit          got_last[$];
   bit          exp_last[$];
   int          got_cyc[$];
   int          exp_cyc[$];

   typedef struct {
      logic [31:0] a;
      int          ln;
      int          rl;
      int          bad;
      int          ard;
      logic [7:0]  gaps;
      int          exp_beats;
      int          exp_err;
   } vec_t;

   vec_t vecs[7];

   axi_dma_r #(.AXI_ID(0), .DATA_REG(1'b1)) dut (
      .clk(clk), .rst(rst), .valid(valid), .addr(addr), .len(len),
      .ready(ready), .rdata(rdata), .last(last), .error(error),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every returned beat with the cycle it was seen in.
   always @(negedge clk) begin
      if (rst && ready) begin
         got_data.push_back(rdata);
         got_last.push_back(last);
         got_cyc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_queues();
      got_data.delete(); got_last.delete(); got_cyc.delete();
      exp_data.delete(); exp_last.delete(); exp_cyc.delete();
   endtask

   task automatic addr_phase(input logic [31:0] a, input int ln, input int ard);
      int arcnt;
      arcnt = 0;
      @(posedge clk); #1;
      valid = 1'b1;
      addr  = a;
      len   = ln[7:0];
      for (int i = 0; i <= ard; i++) begin
         @(negedge clk);
         if (m_axi_arvalid) arcnt++;
         if (i == 0) check("ar_addr_len", {m_axi_araddr, 24'h0, m_axi_arlen}, {a, 24'h0, ln[7:0]});
         if (i == ard) m_axi_arready = 1'b1;
         @(posedge clk); #1;
         m_axi_arready = 1'b0;
      end
      check("arvalid_cycles", 64'(arcnt), 64'(ard + 1));
      check("error_held", 64'(error), 64'(prev_err));
   endtask

   task automatic drive_beat(input int gap, input logic [1:0] resp, input bit lst);
      logic [63:0] d;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      d = {$urandom, $urandom};
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = d;
      m_axi_rresp  = resp;
      m_axi_rlast  = lst;
      exp_data.push_back(d);
      exp_last.push_back(lst);
      exp_cyc.push_back(cyc + 1);
      @(posedge clk); #1;
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
   endtask

   // Drop valid in the idle cycle, poke stray rvalid, then check the burst outcome.
   task automatic finish_burst(input int exp_beats, input int exp_err);
      int arcnt;
      int n;
      arcnt = 0;
      @(negedge clk);
      valid        = 1'b0;
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (m_axi_arvalid) arcnt++;
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      check("no_reissue", 64'(arcnt), 64'(0));
      check("error", 64'(error), 64'(exp_err));
      prev_err = exp_err;
      check("ready_count", 64'(got_data.size()), 64'(exp_beats));
      n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
      for (int i = 0; i < n; i++) begin
         check("beat_data", got_data[i], exp_data[i]);
         check("beat_last_cycle", 64'({got_last[i], got_cyc[i]}), 64'({exp_last[i], exp_cyc[i]}));
      end
      clear_queues();
   endtask

   task automatic run_burst(input logic [31:0] a, input int ln, input int rl, input int bad,
                            input int ard, input logic [7:0] gaps, input bit rnd,
                            input int exp_beats, input int exp_err);
      int gap;
      logic [1:0] resp;
      addr_phase(a, ln, ard);
      for (int b = 0; b <= rl; b++) begin
         if (rnd) gap = $urandom_range(0, 2);
         else if (b < 8) gap = int'(gaps[b]);
         else gap = 0;
         resp = (b == bad) ? (2'b10 | 2'($urandom_range(0, 1))) : 2'b00;
         drive_beat(gap, resp, (b == rl));
      end
      finish_burst(exp_beats, exp_err);
   endtask

   initial begin
      int ln, rl, bad, ard, e;
      logic [31:0] a;

      //            addr       len  rlast bad ar_dly gaps    beats err
      vecs[0] = '{32'h100,   3,   3,  -1,  0,  8'h00,   4,  0};
      vecs[1] = '{32'h140,   0,   0,   0,  0,  8'h00,   1,  1};
      vecs[2] = '{32'h180,   3,   3,  -1,  0,  8'h00,   4,  0};
      vecs[3] = '{32'h1c0,   7,   4,  -1,  1,  8'h00,   5,  1};
      vecs[4] = '{32'h200,   3,   3,  -1,  5,  8'h0a,   4,  0};
      vecs[5] = '{32'h240,   1,   2,  -1,  0,  8'h01,   3,  1};
      vecs[6] = '{32'h1000, 255, 255, -1,  2,  8'h00, 256,  0};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 64'({ready, last, error, m_axi_arvalid, m_axi_rready}), 64'(0));
      check("reset_rdata", rdata, 64'(0));
      rst = 1'b1;
      check("ar_const",
            64'({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos}),
            64'({4'h0, 3'd3, 2'b01, 1'b0, 4'h2, 3'b010, 4'h0}));

      // Directed table.
      for (int i = 0; i < 7; i++) begin
         run_burst(vecs[i].a, vecs[i].ln, vecs[i].rl, vecs[i].bad, vecs[i].ard,
                   vecs[i].gaps, 1'b0, vecs[i].exp_beats, vecs[i].exp_err);
      end

      // Leave error set, then reset in the middle of a burst.
      run_burst(32'h300, 0, 0, 0, 0, 8'h00, 1'b0, 1, 1);
      addr_phase(32'h340, 3, 0);
      drive_beat(0, 2'b00, 1'b0);
      drive_beat(0, 2'b00, 1'b0);
      rst = 1'b0;
      #1;
      check("midburst_rst_ctrl", 64'({ready, last, error, m_axi_arvalid, m_axi_rready}), 64'(0));
      check("midburst_rst_rdata", rdata, 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      prev_err = 0;
      clear_queues();
      run_burst(32'h380, 2, 2, -1, 0, 8'h00, 1'b0, 3, 0);

      // Randomized bursts against the burst-level model.
      for (int k = 0; k < 30; k++) begin
         ln  = $urandom_range(0, 15);
         rl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ln + 2)) : ln;
         bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, rl)) : -1;
         ard = $urandom_range(0, 3);
         a   = $urandom & 32'hffff_fff8;
         e   = ((rl != ln) || (bad >= 0)) ? 1 : 0;
         run_burst(a, ln, rl, bad, ard, 8'h00, 1'b1, rl + 1, e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
